// File: rtl/fetch_queue_if.sv
// -----------------------------------------------------------------------------
// fetch_queue_if
// Bundle of the fetch front end's external signals: redirect port, IMEM
// (BRAM Port A) request/response, and the ID-side valid/ready handshake.
//   master : the fetch_queue side (drives imem_req/addr, id_* outputs)
//   slave  : the environment side (EX redirect, BRAM, decode stage)
// Ports carried:
//   redirect_valid, redirect_pc   : flush/restart request from EX
//   misalign_err                  : redirect target had non-zero low bits
//   imem_req, imem_addr           : fetch request to BRAM
//   imem_rdata                    : BRAM read data, one cycle after imem_req
//   id_valid, id_ready            : handshake towards decode
//   id_instr, id_pc               : queue head contents
//   occupancy                     : number of valid queue entries
// -----------------------------------------------------------------------------
interface fetch_queue_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic              redirect_valid;
    logic [XLEN-1:0]   redirect_pc;
    logic              misalign_err;
    logic              imem_req;
    logic [XLEN-1:0]   imem_addr;
    logic [31:0]       imem_rdata;
    logic              id_valid;
    logic              id_ready;
    logic [31:0]       id_instr;
    logic [XLEN-1:0]   id_pc;
    logic [CNT_W-1:0]  occupancy;

    modport master (
        input  redirect_valid, redirect_pc, imem_rdata, id_ready,
        output misalign_err, imem_req, imem_addr, id_valid, id_instr, id_pc,
               occupancy
    );

    modport slave (
        output redirect_valid, redirect_pc, imem_rdata, id_ready,
        input  misalign_err, imem_req, imem_addr, id_valid, id_instr, id_pc,
               occupancy
    );
endinterface

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// Prefetching PC generator plus a DEPTH-entry instruction queue for the RV32
// pipeline. Requests go to a synchronous BRAM with 1-cycle read latency; the
// returning word is tagged with its PC and queued. Decode pops (instr, pc)
// pairs over valid/ready. A redirect flushes the queue, discards the response
// arriving in the same cycle, and immediately issues a fetch at the target.
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : fetch_queue_if.master (redirect, IMEM and ID handshake signals)
// -----------------------------------------------------------------------------
module fetch_queue #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_queue_if.master bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic [XLEN-1:0]  r_fetch_pc;
    logic             r_inflight;
    logic [XLEN-1:0]  r_inflight_pc;
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    logic [31:0]      r_mem_instr [DEPTH];
    logic [XLEN-1:0]  r_mem_pc    [DEPTH];

    logic             w_id_valid;
    logic             w_pop;
    logic             w_push;
    logic [CNT_W:0]   w_free;
    logic             w_credit;
    logic [XLEN-1:0]  w_redir_pc;

    always_comb begin
        w_id_valid = (r_count != '0);
        // A redirect cycle never consumes the head, even if ID is ready.
        w_pop      = w_id_valid & bus.id_ready & ~bus.redirect_valid;
        // The response landing in a redirect cycle belongs to the old path.
        w_push     = r_inflight & ~bus.redirect_valid;
        // Slots not yet spoken for: in-flight request already owns one, a pop
        // this cycle frees one. count + inflight never exceeds DEPTH, so this
        // cannot underflow.
        w_free     = (CNT_W+1)'(DEPTH) - {1'b0, r_count}
                   - (CNT_W+1)'(r_inflight) + (CNT_W+1)'(w_pop);
        w_credit   = (w_free != '0);
        w_redir_pc = {bus.redirect_pc[XLEN-1:2], 2'b00};
    end

    assign bus.misalign_err = bus.redirect_valid & (|bus.redirect_pc[1:0]);
    // Gated by rst_n so no request is presented while held in reset.
    assign bus.imem_req     = rst_n & (bus.redirect_valid | w_credit);
    assign bus.imem_addr    = bus.redirect_valid ? w_redir_pc : r_fetch_pc;
    assign bus.id_valid     = w_id_valid;
    assign bus.id_instr     = w_id_valid ? r_mem_instr[r_head] : NOP;
    assign bus.id_pc        = w_id_valid ? r_mem_pc[r_head] : '0;
    assign bus.occupancy    = r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc    <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
        end else if (bus.redirect_valid) begin
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
            r_fetch_pc    <= w_redir_pc + XLEN'(4);
            r_inflight    <= 1'b1;
            r_inflight_pc <= w_redir_pc;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            if (w_credit) begin
                r_fetch_pc    <= r_fetch_pc + XLEN'(4);
                r_inflight    <= 1'b1;
                r_inflight_pc <= r_fetch_pc;
            end else begin
                r_inflight    <= 1'b0;
            end
        end
    end

    // Queue storage carries no reset; validity is tracked by r_count alone.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_instr[r_tail] <= bus.imem_rdata;
            r_mem_pc[r_tail]    <= r_inflight_pc;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue
// Bench for fetch_queue: BRAM model returning addr ^ 32'hA5A50000, directed
// scenarios followed by random ready/redirect traffic. Expected outputs come
// from a queue-of-PCs reference model plus a delivered-stream continuity check.
// -----------------------------------------------------------------------------
module tb_fetch_queue;
    localparam int unsigned XLEN     = 32;
    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam logic [31:0] XOR_PAT  = 32'hA5A5_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

    fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Synchronous BRAM port A: data appears the cycle after the request.
    always @(posedge clk) begin
        if (bus.imem_req) bus.imem_rdata <= bus.imem_addr ^ XOR_PAT;
    end

    // Reference model: what the queue holds (as PCs), the outstanding fetch,
    // the next fetch address, and the PC the delivered stream must show next.
    logic [31:0] mq[$];
    bit          m_infl;
    logic [31:0] m_ipc;
    logic [31:0] m_fpc;
    logic [31:0] m_stream;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_infl   = 1'b0;
        m_ipc    = '0;
        m_fpc    = RESET_PC;
        m_stream = RESET_PC;
    endtask

    // One clock cycle: drive inputs at negedge, compare outputs, advance model.
    task automatic step(input bit rdy, input bit rv, input logic [31:0] rpc);
        logic [31:0] al;
        logic [31:0] head_pc;
        bit          pop;
        int          sz;
        int          free;
        @(negedge clk);
        bus.id_ready       = rdy;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        #1;
        sz      = mq.size();
        al      = {rpc[31:2], 2'b00};
        head_pc = '0;
        if (sz > 0) head_pc = mq[0];
        pop  = (sz > 0) && rdy && !rv;
        free = DEPTH - sz - int'(m_infl) + int'(pop);
        chk("id_valid",     32'(bus.id_valid),     32'(sz > 0));
        chk("id_pc",        bus.id_pc,             head_pc);
        chk("id_instr",     bus.id_instr,          (sz > 0) ? (head_pc ^ XOR_PAT) : NOP);
        chk("occupancy",    32'(bus.occupancy),    32'(sz));
        chk("imem_req",     32'(bus.imem_req),     32'(rv || free > 0));
        chk("imem_addr",    bus.imem_addr,         rv ? al : m_fpc);
        chk("misalign_err", 32'(bus.misalign_err), 32'(rv && (rpc[1:0] != 2'b00)));
        if (pop) begin
            chk("stream_pc", bus.id_pc, m_stream);
            m_stream += 32'd4;
        end
        @(posedge clk);
        if (rv) begin
            mq.delete();
            m_infl   = 1'b1;
            m_ipc    = al;
            m_fpc    = al + 32'd4;
            m_stream = al;
        end else begin
            if (pop) void'(mq.pop_front());
            if (m_infl) mq.push_back(m_ipc);
            if (free > 0) begin
                m_infl = 1'b1;
                m_ipc  = m_fpc;
                m_fpc  = m_fpc + 32'd4;
            end else begin
                m_infl = 1'b0;
            end
        end
    endtask

    // Assert reset (checking its immediate effect), then release just after a
    // rising edge so the next cycle is the first fetch cycle.
    task automatic do_reset();
        @(negedge clk);
        rst_n              = 1'b0;
        bus.redirect_valid = 1'b0;
        #1;
        chk("rst_id_valid",  32'(bus.id_valid),  32'd0);
        chk("rst_id_instr",  bus.id_instr,       NOP);
        chk("rst_id_pc",     bus.id_pc,          32'd0);
        chk("rst_occupancy", 32'(bus.occupancy), 32'd0);
        chk("rst_imem_req",  32'(bus.imem_req),  32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        bus.id_ready       = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        model_reset();

        // Reset release, streaming with ID always ready.
        do_reset();
        repeat (10) step(1'b1, 1'b0, 32'h0);

        // Stall ID for 10 cycles: queue fills to DEPTH and fetch stops.
        repeat (10) step(1'b0, 1'b0, 32'h0);
        #1;
        chk("stall_occupancy", 32'(bus.occupancy), 32'(DEPTH));
        chk("stall_imem_req",  32'(bus.imem_req),  32'd0);
        repeat (10) step(1'b1, 1'b0, 32'h0);

        // Three queued entries plus one in flight, then redirect to 0x100.
        do_reset();
        repeat (4) step(1'b0, 1'b0, 32'h0);
        #1;
        chk("pre_redirect_occupancy", 32'(bus.occupancy), 32'd3);
        step(1'b1, 1'b1, 32'h100);
        #1;
        chk("post_redirect_occupancy", 32'(bus.occupancy), 32'd0);
        repeat (8) step(1'b1, 1'b0, 32'h0);

        // Redirect coinciding with a valid head and ID ready.
        step(1'b1, 1'b1, 32'h40);
        repeat (6) step(1'b1, 1'b0, 32'h0);

        // Back-to-back redirects, the second misaligned.
        step(1'b1, 1'b1, 32'h200);
        step(1'b1, 1'b1, 32'h302);
        repeat (6) step(1'b1, 1'b0, 32'h0);

        // Reset in the middle of a stream.
        repeat (3) step(1'b1, 1'b0, 32'h0);
        do_reset();
        repeat (6) step(1'b1, 1'b0, 32'h0);

        // Random ready / redirect traffic.
        for (int i = 0; i < 400; i++) begin
            bit          rdy;
            bit          rv;
            logic [31:0] rpc;
            rdy = ($urandom_range(0, 3) != 0);
            rv  = ($urandom_range(0, 15) == 0);
            rpc = $urandom & 32'h0000_0FFF;
            step(rdy, rv, rpc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
Parametrised instruction-fetch front end for the pipelined RV32 core. It replaces the bare IF program counter with a prefetching PC generator plus a DEPTH-entry instruction queue, so IMEM fetch is decoupled from decode stalls. It drives Port A of the synchronous BRAM, which has 1-cycle read latency. It delivers (instr, pc) pairs to ID over a valid/ready handshake. A redirect port (branch/jump resolved in EX) flushes the queue and kills any in-flight fetch.

Parameters:
XLEN, 32, PC/address width.
DEPTH, 4, queue entries; power of two, >= 2.
RESET_PC, 0, first fetch address after reset; word aligned.

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
redirect_valid  in  1  flush queue and restart fetch this cycle
redirect_pc  in  XLEN  new fetch address; bits [1:0] ignored
misalign_err  out  1  redirect_valid & |redirect_pc[1:0] (combinational)
imem_req  out  1  fetch issued this cycle
imem_addr  out  XLEN  fetch address (BRAM addra)
imem_rdata  in  32  BRAM doa; valid the cycle after imem_req
id_valid  out  1  queue head valid
id_ready  in  1  ID accepts head
id_instr  out  32  head instruction; 32'h00000013 (NOP) when empty
id_pc  out  XLEN  head PC; 0 when empty
occupancy  out  $clog2(DEPTH+1)  valid entries in queue

Behaviour:
- Reset (async, immediate):
  - fetch_pc = RESET_PC; head/tail pointers = 0; count = 0; inflight = 0.
  - Outputs: imem_req = 0, id_valid = 0, id_instr = NOP, id_pc = 0, occupancy = 0.
- State:
  - fetch_pc: next fetch address.
  - inflight: 1-bit flag; set when a request was issued last cycle.
  - inflight_pc: PC tag of that request.
  - Queue storage: DEPTH x (32 + XLEN), with head and tail pointers and count.
- Pop: pop = id_valid & id_ready & ~redirect_valid.
- Credit: free = DEPTH - count - inflight + pop. A request is issued only when free > 0. Overflow is therefore impossible, and throughput of 1 instr/cycle is sustained for DEPTH >= 2.
- Normal issue (no redirect, free > 0):
  - imem_req = 1, imem_addr = fetch_pc.
  - At clk: fetch_pc += 4, inflight <= 1, inflight_pc <= fetch_pc.
  - When free = 0: imem_req = 0, imem_addr = fetch_pc, fetch_pc holds, inflight <= 0.
- Response:
  - When inflight = 1 and no redirect this cycle, {imem_rdata, inflight_pc} is written at tail at clk and tail advances.
  - Latency: request in cycle T gives id_valid no earlier than T+2. There is no bypass.
- Counters:
  - count <= count + push - pop.
  - Head and tail wrap modulo DEPTH.
  - Simultaneous push and pop at any occupancy leaves count unchanged.
- Redirect (cycle N):
  - Queue flushed at clk (count = 0, head = tail).
  - The response arriving in cycle N is discarded.
  - The handshake is ignored in cycle N (no pop).
  - In the same cycle: imem_req = 1, imem_addr = {redirect_pc[XLEN-1:2], 2'b00}.
  - At clk: fetch_pc <= aligned redirect_pc + 4, inflight <= 1, inflight_pc <= aligned redirect_pc.
  - First redirected instruction is visible on ID at N+2.
- Back-to-back redirects: the last one wins; the earlier target's response is discarded by the same rule.
- Empty: id_valid = 0 and the NOP/0 outputs are driven; id_ready is don't-care.
- Full (count = DEPTH, no pop): imem_req = 0.
- Reset mid-operation: an in-flight response is dropped because inflight is cleared. Fetch restarts at RESET_PC on the first clk after rst_n deasserts.
- id_instr, id_pc and occupancy are driven from registered state only, with no combinational path from id_ready. Exception: imem_req/imem_addr depend on id_ready and redirect via pop and free.

Test Plan:
1. Reset release, id_ready = 1, IMEM model returns addr ^ 32'hA5A50000.
   -> First id_valid at cycle 2 with pc = 0x0, then pc 0x4, 0x8, 0xC on consecutive cycles with no bubble.
2. DEPTH = 4, id_ready = 0 for 10 cycles, then 1.
   -> occupancy saturates at 4 and imem_req = 0 while full.
   -> After release, the pc sequence resumes contiguously (no loss, no duplicate).
3. Queue holds 3 entries plus one in flight; redirect_valid = 1 with redirect_pc = 0x100.
   -> occupancy = 0 next cycle.
   -> id_valid rises 2 cycles later with pc = 0x100, then 0x104; no stale pc appears.
4. Redirect coincident with id_valid & id_ready.
   -> Head is not consumed twice; next accepted pc = redirect target.
5. Redirect to 0x200, then 0x302 the next cycle.
   -> misalign_err = 1 in the second cycle.
   -> The stream starts at 0x300; no 0x200 instruction is delivered.
6. rst_n asserted mid-stream.
   -> id_valid = 0, id_instr = 0x00000013, occupancy = 0 immediately.
   -> After release, pc restarts at RESET_PC.
